// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between IF and MEM ports
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        bus_err,
    output logic [31:0] stall_cnt
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;
    state_t state_q, state_d;

    logic          i_done, d_done;
    logic [CW-1:0] to_cnt;
    logic          d_req, advance, timeout, finish;
    logic          credit_d, credit_i;
    logic          issue_d, issue_i, done_d, done_i, drop;
    logic [31:0]   rdata_eff;

    assign d_req      = mem_ren | mem_wen;
    assign inst_stall = inst_ren & ~i_done;
    assign mem_stall  = d_req & ~d_done;
    assign advance    = ~inst_stall & ~mem_stall;

    // Ack beats timeout on the same edge; a timed-out read returns all ones.
    assign timeout   = ram_cs & ~ram_ack & (to_cnt == CW'(TIMEOUT));
    assign finish    = (state_q != IDLE) & (ram_ack | timeout);
    assign rdata_eff = ram_ack ? ram_rdata : 32'hFFFF_FFFF;

    // A completion only counts if the requester still presents the same access.
    assign credit_d = d_req & (mem_wen == ram_we) & (mem_addr == ram_addr);
    assign credit_i = inst_ren & (inst_addr == ram_addr);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_stall)       state_d = D_BUSY;
                else if (inst_stall) state_d = I_BUSY;
            end
            D_BUSY: begin
                if (finish) state_d = inst_stall ? I_BUSY : IDLE;
            end
            I_BUSY: begin
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_d = (state_q == IDLE) & mem_stall;
        issue_i = ((state_q == IDLE) & ~mem_stall & inst_stall) |
                  ((state_q == D_BUSY) & finish & inst_stall);
        done_d  = (state_q == D_BUSY) & finish & credit_d;
        done_i  = (state_q == I_BUSY) & finish & credit_i;
        drop    = finish & ~issue_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'd0;
            ram_wdata <= 32'd0;
            inst_data <= 32'd0;
            mem_din   <= 32'd0;
            bus_err   <= 1'b0;
            stall_cnt <= 32'd0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (issue_d) begin
                ram_cs    <= 1'b1;
                ram_we    <= mem_wen;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_dout;
                to_cnt    <= CW'(1);
            end else if (issue_i) begin
                ram_cs   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= inst_addr;
                to_cnt   <= CW'(1);
            end else if (drop) begin
                ram_cs <= 1'b0;
                ram_we <= 1'b0;
                to_cnt <= '0;
            end else if (ram_cs) begin
                to_cnt <= to_cnt + CW'(1);
            end

            if (done_d && !ram_we) mem_din <= rdata_eff;
            if (done_i)            inst_data <= rdata_eff;
            if (timeout && state_q != IDLE) bus_err <= 1'b1;

            if (done_d)       d_done <= 1'b1;
            else if (advance) d_done <= 1'b0;
            if (done_i)       i_done <= 1'b1;
            else if (advance) i_done <= 1'b0;

            if (inst_stall | mem_stall) stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren, mem_ren, mem_wen, ram_ack;
    logic [31:0] inst_addr, mem_addr, mem_dout, ram_rdata;
    logic [31:0] inst_data, mem_din, ram_addr, ram_wdata, stall_cnt;
    logic        inst_stall, mem_stall, ram_cs, ram_we, bus_err;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_stall(mem_stall),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];
    int          lat = 1;
    bit          rand_lat = 0;
    bit          force_ack = 0;
    logic [31:0] force_data = 32'h0;
    int          rcyc = 0;
    int          cur_lat = 0;
    int          wr_count = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    // Memory responder: acks after cur_lat cycles of ram_cs high (0 = never).
    always @(posedge clk) begin
        #2;
        ram_ack   = 1'b0;
        ram_rdata = 32'h0;
        if (force_ack) begin
            ram_ack   = 1'b1;
            ram_rdata = force_data;
        end else if (ram_cs) begin
            if (rcyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 3)) : lat;
            rcyc++;
            if (cur_lat != 0 && rcyc == cur_lat) begin
                ram_ack = 1'b1;
                if (ram_we) begin
                    ram[ram_addr] = ram_wdata;
                    wr_count++;
                end else begin
                    ram_rdata = ram_word(ram_addr);
                end
                rcyc = 0;
            end
        end else begin
            rcyc = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_ren = 0; inst_addr = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        force_ack = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int wbase;
        int exp_stall;
        int op;
        logic [31:0] exp_din;

        ram_ack = 0; ram_rdata = 0;

        // Reset state
        lat = 1;
        do_reset();
        look();
        chk("rst_ram_cs", 32'(ram_cs), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_stalls", {30'd0, inst_stall, mem_stall}, 0);

        // Single fetch, latency 1
        ram[32'h0] = 32'h2008_0001;
        do_reset();
        inst_ren = 1; inst_addr = 32'h0;
        look();
        chk("sf_c0_stall", 32'(inst_stall), 1);
        tick(); look();
        chk("sf_c1_cs", 32'(ram_cs), 1);
        chk("sf_c1_addr", ram_addr, 0);
        chk("sf_c1_stall", 32'(inst_stall), 1);
        tick(); look();
        chk("sf_c2_stall", 32'(inst_stall), 0);
        chk("sf_c2_data", inst_data, 32'h2008_0001);

        // Contention: data first, then fetch back-to-back
        ram[32'h100] = 32'h1111_0100;
        ram[32'h4]   = 32'h2222_0004;
        do_reset();
        mem_ren = 1; mem_addr = 32'h100; inst_ren = 1; inst_addr = 32'h4;
        tick(); look();
        chk("ct_c1_cs", 32'(ram_cs), 1);
        chk("ct_c1_addr", ram_addr, 32'h100);
        tick(); look();
        chk("ct_c2_cs", 32'(ram_cs), 1);
        chk("ct_c2_addr", ram_addr, 32'h4);
        chk("ct_c2_mem_stall", 32'(mem_stall), 0);
        tick(); look();
        chk("ct_c3_stalls", {30'd0, inst_stall, mem_stall}, 0);
        chk("ct_c3_stall_cnt", stall_cnt, 3);
        chk("ct_c3_mem_din", mem_din, 32'h1111_0100);
        chk("ct_c3_inst_data", inst_data, 32'h2222_0004);

        // Write, latency 3, fetch pending
        lat = 3;
        do_reset();
        wbase = wr_count;
        mem_wen = 1; mem_addr = 32'h200; mem_dout = 32'hDEAD_BEEF; inst_ren = 1; inst_addr = 32'h8;
        for (int c = 1; c <= 3; c++) begin
            tick(); look();
            chk("wr_cs", 32'(ram_cs), 1);
            chk("wr_we", 32'(ram_we), 1);
            chk("wr_addr", ram_addr, 32'h200);
            chk("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
        end
        tick(); look();
        chk("wr_c4_fetch_addr", ram_addr, 32'h8);
        chk("wr_c4_we", 32'(ram_we), 0);
        tick(); tick(); tick(); look();
        chk("wr_c7_stalls", {30'd0, inst_stall, mem_stall}, 0);
        tick();
        idle_inputs();
        look();
        chk("wr_once", 32'(wr_count - wbase), 1);
        chk("wr_mem_din", mem_din, 0);
        chk("wr_c8_cs", 32'(ram_cs), 0);

        // Timeout (TIMEOUT=4), no ack
        lat = 0;
        do_reset();
        mem_ren = 1; mem_addr = 32'h300;
        for (int c = 1; c <= 4; c++) begin
            tick(); look();
            chk("to_cs_high", 32'(ram_cs), 1);
            chk("to_no_err", 32'(bus_err), 0);
        end
        tick(); look();
        chk("to_c5_cs", 32'(ram_cs), 0);
        chk("to_c5_err", 32'(bus_err), 1);
        chk("to_c5_din", mem_din, 32'hFFFF_FFFF);
        chk("to_c5_stall", 32'(mem_stall), 0);
        tick();
        idle_inputs();
        force_ack = 1; force_data = 32'h1234_5678;
        tick(); tick();
        force_ack = 0;
        look();
        chk("to_late_ack_din", mem_din, 32'hFFFF_FFFF);
        chk("to_late_ack_cs", 32'(ram_cs), 0);
        chk("to_err_sticky", 32'(bus_err), 1);

        // Reset mid-access
        lat = 3;
        do_reset();
        inst_ren = 1; inst_addr = 32'h10;
        tick(); look();
        chk("rm_c1_cs", 32'(ram_cs), 1);
        tick();
        rst = 1;
        tick();
        rst = 0; inst_ren = 0; force_ack = 1; force_data = 32'hCAFE_0001;
        look();
        chk("rm_c3_cs", 32'(ram_cs), 0);
        tick();
        force_ack = 0;
        look();
        chk("rm_inst_data", inst_data, 0);
        chk("rm_cs", 32'(ram_cs), 0);
        chk("rm_bus_err", 32'(bus_err), 0);
        chk("rm_stall_cnt", stall_cnt, 0);

        // Redirect mid-access: result for 0x8 discarded
        ram[32'h8]  = 32'h0808_0808;
        ram[32'h40] = 32'h4040_4040;
        do_reset();
        inst_ren = 1; inst_addr = 32'h8;
        tick();
        inst_addr = 32'h40;
        look();
        chk("rd_c1_addr", ram_addr, 32'h8);
        tick(); tick(); tick(); look();
        chk("rd_c4_cs", 32'(ram_cs), 0);
        chk("rd_c4_stall", 32'(inst_stall), 1);
        chk("rd_c4_data", inst_data, 0);
        tick(); look();
        chk("rd_c5_addr", ram_addr, 32'h40);
        tick(); tick(); tick(); look();
        chk("rd_c8_stall", 32'(inst_stall), 0);
        chk("rd_c8_data", inst_data, 32'h4040_4040);
        tick();
        idle_inputs();

        // Randomized pipeline steps against a step-level memory model
        rand_lat = 1;
        do_reset();
        ram.delete();
        model_mem.delete();
        exp_stall = 0;
        exp_din = 0;
        for (int s = 0; s < 80; s++) begin
            inst_ren  = ($urandom_range(0, 3) != 0);
            inst_addr = 32'($urandom_range(0, 15)) << 2;
            op        = int'($urandom_range(0, 3));
            mem_ren   = (op == 1) || (op == 3);
            mem_wen   = (op >= 2);
            mem_addr  = 32'($urandom_range(0, 15)) << 2;
            mem_dout  = $urandom;
            wbase = wr_count;
            n = 0;
            look();
            while ((inst_stall || mem_stall) && n < 30) begin
                tick(); look();
                n++;
            end
            chk("rs_step_done", {30'd0, inst_stall, mem_stall}, 0);
            if (mem_wen) model_mem[mem_addr] = mem_dout;
            else if (mem_ren) exp_din = model_word(mem_addr);
            chk("rs_mem_din", mem_din, exp_din);
            if (inst_ren) chk("rs_inst_data", inst_data, model_word(inst_addr));
            chk("rs_writes", 32'(wr_count - wbase), mem_wen ? 1 : 0);
            exp_stall += n;
            tick();
        end
        idle_inputs();
        look();
        chk("rs_stall_cnt", stall_cnt, 32'(exp_stall));
        chk("rs_no_bus_err", 32'(bus_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
